instr_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decoder. Maintains the program counter, issues word reads to instruction memory over a valid/ready request channel, and accepts in-order responses. Buffers fetched words with their PCs in a small FIFO, then presents them to the decoder over a valid/ready handshake. Handles control-flow redirects by flushing buffered and in-flight fetches.

---
 rtl/rv_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: types and constants shared by the front-end pipeline stages.
//   XLEN / INSTR_W   : address and instruction widths
//   DEFAULT_RESET_PC : boot address used when a stage is not told otherwise
//   NOP_INSTR        : canonical RV32I nop (addi x0, x0, 0)
//   fetch_state_t    : fetch stage control state
//   fetch_entry_t    : one buffered fetch result {pc, instr}
package rv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Clear the byte offset so every address handed to memory is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched {pc, instr} entries.
//   clk, rst_n   : clock, synchronous active-low reset
//   push / wdata : write an entry (ignored when full unless a pop frees a slot)
//   pop  / rdata : rdata is the current head; pop advances it (ignored when empty)
//   clear        : drop every entry; wins over a same-cycle push
//   count, empty, full : occupancy status of the registered state
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, instruction memory request/response handling
// and decoder-facing buffer.
//   clk, rst_n                    : clock, synchronous active-low reset
//   imem_req_valid/ready/addr     : word read requests to instruction memory
//   imem_rsp_valid/data           : in-order read responses
//   redirect_valid/pc             : control-flow redirect pulse and target
//   out_valid/ready, out_instr/pc : instruction stream to the decoder
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t   state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full, fifo_push, fifo_pop;
    fetch_entry_t    push_entry, head_entry;
    logic            req_fire, rsp_accept, credit_ok;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = word_align(redirect_pc);

    // Every in-flight request owns a FIFO slot, so the buffer can never overflow.
    assign credit_ok = (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH))
                       && !fifo_full;

    assign req_fire   = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is dropped.
    assign rsp_accept = imem_rsp_valid && (outstanding_q != '0);
    // Redirect beats a same-cycle response: the word belongs to the old path.
    assign fifo_push  = rsp_accept && (state_q == FETCH) && !redirect_valid;
    assign fifo_pop   = out_valid && out_ready;

    assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_accept);

    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    always_comb begin
        req_pc_d = req_pc_q;
        rsp_pc_d = rsp_pc_q;
        if (req_fire)  req_pc_d = req_pc_q + 32'd4;
        if (fifo_push) rsp_pc_d = rsp_pc_q + 32'd4;
        if (redirect_valid) begin
            req_pc_d = redirect_target;
            rsp_pc_d = redirect_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_pc_q      <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next state: anything still in flight after a redirect is stale and
    // must drain before fetching resumes on the new path.
    always_comb begin
        state_d = state_q;
        if (redirect_valid)
            state_d = (outstanding_d != '0) ? FLUSH : FETCH;
        else if ((state_q == FLUSH) && (outstanding_d == '0))
            state_d = FETCH;
    end

    // Outputs: rst_n gating keeps both valids low through a multi-cycle reset.
    always_comb begin
        imem_req_valid = rst_n && (state_q == FETCH) && credit_ok && !redirect_valid;
        imem_req_addr  = req_pc_q;
    end

    assign out_valid = rst_n && !fifo_empty && !redirect_valid;
    assign out_instr = fifo_empty ? NOP_INSTR : head_entry.instr;
    assign out_pc    = head_entry.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (redirect_valid),
        .wdata (push_entry),
        .rdata (head_entry),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    // Reference model: memory holds accepted requests in order; the decoder
    // must see consecutive PCs starting at the last redirect/reset target.
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] ghostq[$];      // requests orphaned by a reset
    logic [31:0] fire_log[$];    // DUT addresses of accepted requests
    logic [31:0] pop_log[$];     // DUT out_pc of consumed instructions
    int          buf_cnt = 0;
    logic [31:0] exp_req_pc = RST_PC;
    logic [31:0] exp_out_pc = RST_PC;
    int unsigned cyc = 0;
    int          rdy_pct = 100, rsp_pct = 100, ordy_pct = 100, lat = 1;
    bit          redir_req = 0;
    logic [31:0] redir_tgt = '0;
    logic        obs_out_valid;
    int          vectors = 0, miscompares = 0;

    task automatic tick();
        bit          rsp_go, from_ghost, exp_rv, exp_ov;
        int          stale_n;
        mreq_t       m;
        @(negedge clk);
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        out_ready      = ($urandom_range(99) < ordy_pct);
        rsp_go = 0; from_ghost = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (ghostq.size() > 0) begin
            if ($urandom_range(99) < rsp_pct) begin
                rsp_go = 1; from_ghost = 1;
                imem_rsp_data = ghostq[0] ^ KEY;
            end
        end else if (memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
            rsp_go = 1;
            imem_rsp_data = memq[0].addr ^ KEY;
        end
        imem_rsp_valid = rsp_go;
        redirect_valid = redir_req;
        redirect_pc    = redir_tgt;
        redir_req      = 0;
        #1;
        stale_n = 0;
        foreach (memq[i]) if (memq[i].stale) stale_n++;
        exp_rv = (stale_n == 0) && (memq.size() + buf_cnt < DEPTH) && !redirect_valid;
        exp_ov = (buf_cnt > 0) && !redirect_valid;
        obs_out_valid = out_valid;

        vectors++;
        if (imem_req_valid !== exp_rv) begin
            miscompares++;
            $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, imem_req_valid, exp_rv);
        end
        if (exp_rv) begin
            vectors++;
            if (imem_req_addr !== exp_req_pc) begin
                miscompares++;
                $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_req_addr, exp_req_pc);
            end
        end
        vectors++;
        if (out_valid !== exp_ov) begin
            miscompares++;
            $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, out_valid, exp_ov);
        end
        if (exp_ov) begin
            vectors++;
            if (out_pc !== exp_out_pc) begin
                miscompares++;
                $display("FAIL out_pc cyc=%0d: got %h expected %h", cyc, out_pc, exp_out_pc);
            end
            vectors++;
            if (out_instr !== (exp_out_pc ^ KEY)) begin
                miscompares++;
                $display("FAIL out_instr cyc=%0d: got %h expected %h", cyc, out_instr, exp_out_pc ^ KEY);
            end
        end

        if (rsp_go) begin
            if (from_ghost) void'(ghostq.pop_front());
            else begin
                m = memq.pop_front();
                if (!m.stale && !redirect_valid) buf_cnt++;
            end
        end
        if (exp_ov && out_ready) begin
            pop_log.push_back(out_pc);
            exp_out_pc += 32'd4;
            buf_cnt--;
        end
        if (exp_rv && imem_req_ready) begin
            fire_log.push_back(imem_req_addr);
            memq.push_back('{addr: exp_req_pc, due: cyc + lat, stale: 1'b0});
            exp_req_pc += 32'd4;
        end
        if (redirect_valid) begin
            buf_cnt = 0;
            foreach (memq[i]) memq[i].stale = 1'b1;
            exp_req_pc = redirect_pc & 32'hFFFF_FFFC;
            exp_out_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        cyc++;
    endtask

    task automatic do_reset();
        int guard;
        @(negedge clk);
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0; out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            vectors++;
            if (imem_req_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
            end
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out_valid: got %b expected 0", out_valid);
            end
        end
        foreach (memq[i]) ghostq.push_back(memq[i].addr);
        memq.delete();
        buf_cnt = 0;
        exp_req_pc = RST_PC;
        exp_out_pc = RST_PC;
        rst_n = 1'b1;
        // Stray responses arrive with nothing outstanding and must vanish.
        rdy_pct = 0; rsp_pct = 100; ordy_pct = 100;
        guard = 0;
        while (ghostq.size() > 0 && guard < 20) begin
            tick();
            guard++;
        end
    endtask

    task automatic expect_log(input string name, input logic [31:0] lg[$], input int idx,
                              input logic [31:0] exp);
        vectors++;
        if (idx >= lg.size()) begin
            miscompares++;
            $display("FAIL %s: entry %0d missing, expected %h", name, idx, exp);
        end else if (lg[idx] !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, lg[idx], exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        rdy_pct = 0; ordy_pct = 100; lat = 1;
        tick();   // request to RESET_PC held without ready
        tick();
    endtask

    task automatic test_stream();
        int p0;
        do_reset();
        rdy_pct = 100; rsp_pct = 100; ordy_pct = 100; lat = 1;
        p0 = pop_log.size();
        repeat (20) tick();
        vectors++;
        if (pop_log.size() - p0 != 18) begin
            miscompares++;
            $display("FAIL stream_throughput: got %0d pops expected 18", pop_log.size() - p0);
        end
        for (int k = 0; k < 4; k++) expect_log("stream_pc", pop_log, p0 + k, RST_PC + 32'(4 * k));
    endtask

    task automatic test_backpressure();
        int f0, p0;
        do_reset();
        rdy_pct = 100; rsp_pct = 100; ordy_pct = 0; lat = 1;
        f0 = fire_log.size();
        repeat (10) tick();
        vectors++;
        if (fire_log.size() - f0 != DEPTH) begin
            miscompares++;
            $display("FAIL bp_fires: got %0d expected %0d", fire_log.size() - f0, DEPTH);
        end
        p0 = pop_log.size();
        ordy_pct = 100;
        repeat (6) tick();
        for (int k = 0; k < 4; k++) expect_log("bp_drain_pc", pop_log, p0 + k, 32'(4 * k));
    endtask

    task automatic test_redirect_flush();
        int f0, p0, guard;
        do_reset();
        rdy_pct = 100; rsp_pct = 100; ordy_pct = 100; lat = 3;
        guard = 0;
        while (memq.size() != 2 && guard < 20) begin tick(); guard++; end
        if (guard >= 20) begin
            vectors++; miscompares++;
            $display("FAIL flush_setup: got %0d outstanding expected 2", memq.size());
        end
        redir_req = 1; redir_tgt = 32'h0000_1002;
        tick();
        f0 = fire_log.size(); p0 = pop_log.size();
        repeat (2) begin
            tick();
            vectors++;
            if (obs_out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_out_valid: got %b expected 0", obs_out_valid);
            end
        end
        repeat (10) tick();
        expect_log("flush_first_req", fire_log, f0, 32'h0000_1000);
        expect_log("flush_first_pc", pop_log, p0, 32'h0000_1000);
    endtask

    task automatic test_redirect_collide();
        int p0, guard;
        do_reset();
        rdy_pct = 100; rsp_pct = 100; ordy_pct = 100; lat = 1;
        guard = 0;
        while (!(buf_cnt > 0 && memq.size() > 0 && memq[0].due <= cyc) && guard < 20) begin
            tick(); guard++;
        end
        redir_req = 1; redir_tgt = 32'h0000_2000;
        p0 = pop_log.size();
        tick();
        vectors++;
        if (obs_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_out_valid: got %b expected 0", obs_out_valid);
        end
        tick();
        vectors++;
        if (obs_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_fifo_empty: got %b expected 0", obs_out_valid);
        end
        repeat (6) tick();
        expect_log("collide_first_pc", pop_log, p0, 32'h0000_2000);
    endtask

    task automatic test_wrap();
        int f0, p0;
        logic [31:0] wexp[3];
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
        do_reset();
        rdy_pct = 100; rsp_pct = 100; ordy_pct = 100; lat = 1;
        repeat (3) tick();
        redir_req = 1; redir_tgt = 32'hFFFF_FFF8;
        tick();
        f0 = fire_log.size(); p0 = pop_log.size();
        repeat (10) tick();
        for (int k = 0; k < 3; k++) begin
            expect_log("wrap_req", fire_log, f0 + k, wexp[k]);
            expect_log("wrap_pc", pop_log, p0 + k, wexp[k]);
        end
    endtask

    task automatic test_reset_midflight();
        int p0;
        do_reset();
        rdy_pct = 100; rsp_pct = 100; ordy_pct = 0; lat = 3;
        repeat (4) tick();
        do_reset();
        rdy_pct = 100; rsp_pct = 100; ordy_pct = 100; lat = 1;
        p0 = pop_log.size();
        repeat (6) tick();
        expect_log("post_reset_pc", pop_log, p0, RST_PC);
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) begin
                lat      = $urandom_range(5, 1);
                rdy_pct  = $urandom_range(100, 30);
                rsp_pct  = $urandom_range(100, 30);
                ordy_pct = $urandom_range(100, 20);
            end
            if ($urandom_range(99) < 3) begin
                redir_req = 1;
                redir_tgt = $urandom;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_collide();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
